// File: rtl/spu_dm_arbiter_pkg.sv
// spu_dm_pkg: shared constants and types for the SPU data-memory arbiter.
// Build option: SPU_DM_ARB_LOCK_EN adds per-port lock inputs.
package spu_dm_pkg;

    localparam int unsigned DM_AW = 8;
    localparam int unsigned DM_DW = 16;

    localparam logic PORT_SPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

endpackage

// File: rtl/spu_dm_arbiter_if.sv
// spu_dm_arbiter_if: requester handshakes (SPU port 0, host port 1) and dm pins.
// Build option: SPU_DM_ARB_LOCK_EN adds p0_lock/p1_lock.
interface spu_dm_arbiter_if
    import spu_dm_pkg::*;
#(
    parameter int unsigned AW = DM_AW,
    parameter int unsigned DW = DM_DW
);

    logic          p0_req,    p1_req;
    logic          p0_wr,     p1_wr;
    logic [AW-1:0] p0_addr,   p1_addr;
    logic [DW-1:0] p0_wdata,  p1_wdata;
    logic          p0_gnt,    p1_gnt;
    logic          p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata,  p1_rdata;
`ifdef SPU_DM_ARB_LOCK_EN
    logic          p0_lock,   p1_lock;
`endif
    logic [AW-1:0] dm_addr;
    logic          dm_rd;
    logic          dm_wr;
    logic [DW-1:0] dm_w_data;
    logic [DW-1:0] dm_r_data;
    logic          busy;

    modport slave (
        input  p0_req, p0_wr, p0_addr, p0_wdata,
        input  p1_req, p1_wr, p1_addr, p1_wdata,
`ifdef SPU_DM_ARB_LOCK_EN
        input  p0_lock, p1_lock,
`endif
        input  dm_r_data,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output dm_addr, dm_rd, dm_wr, dm_w_data, busy
    );

    modport master (
        output p0_req, p0_wr, p0_addr, p0_wdata,
        output p1_req, p1_wr, p1_addr, p1_wdata,
`ifdef SPU_DM_ARB_LOCK_EN
        output p0_lock, p1_lock,
`endif
        output dm_r_data,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  dm_addr, dm_rd, dm_wr, dm_w_data, busy
    );

endinterface

// File: rtl/spu_dm_arbiter_pick.sv
// spu_dm_arb_pick: combinational winner selection between the two dm requesters.
module spu_dm_arb_pick
    import spu_dm_pkg::*;
#(
    parameter prio_mode_e MODE = PRIO_RR
) (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  logic       starve,
    output logic [1:0] gnt
);

    // One-hot winner; a tie goes to the rr pointer or to port 0 unless port 1 is starved
    always_comb begin
        gnt = '0;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (MODE == PRIO_RR) gnt = rr_ptr ? 2'b10 : 2'b01;
                else                 gnt = starve ? 2'b10 : 2'b01;
            end
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/spu_dm_arbiter.sv
// spu_dm_arbiter: shares the SPU single-port dm between the controller and host.
// Grant in cycle N, dm pins registered in N+1, read data returned in N+2.
// Build option: SPU_DM_ARB_LOCK_EN enables lock-based ownership for RMW sequences.
module spu_dm_arbiter
    import spu_dm_pkg::*;
#(
    parameter int unsigned AW         = DM_AW,
    parameter int unsigned DW         = DM_DW,
    parameter int unsigned PRIO_MODE  = 0,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic             clk,
    input logic             rst,
    spu_dm_arbiter_if.slave bus
);

    localparam prio_mode_e MODE       = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]    req, req_elig, pick_gnt, gnt;
    logic          gnt_any, gnt_id, gnt_wr;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;
    logic          rr_ptr, starve, freeze;
    logic [3:0]    starve_cnt;
    logic [AW-1:0] dm_addr_q;
    logic [DW-1:0] dm_w_data_q;
    logic          dm_rd_q, dm_wr_q, iss_tag;
    logic          ret_vld, ret_rd, ret_tag;
    logic          rvalid0, rvalid1;

    assign req = {bus.p1_req, bus.p0_req};

`ifdef SPU_DM_ARB_LOCK_EN
    logic locked, lock_owner, gnt_lock;

    assign gnt_lock = gnt_id ? bus.p1_lock : bus.p0_lock;
    assign freeze   = locked;

    // An owner that still requests shuts the other port out
    always_comb begin
        req_elig = req;
        if (locked && req[lock_owner]) req_elig = lock_owner ? 2'b10 : 2'b01;
    end

    // Ownership: taken by a locked grant, dropped by an unlocked grant or by the owner releasing req
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (gnt_any) begin
            locked     <= gnt_lock;
            lock_owner <= gnt_id;
        end else if (locked && !req[lock_owner]) begin
            locked <= 1'b0;
        end
    end
`else
    assign req_elig = req;
    assign freeze   = 1'b0;
`endif

    assign starve = (MODE == PRIO_FIXED) && (starve_cnt == STARVE_LIM);

    spu_dm_arb_pick #(.MODE(MODE)) u_pick (
        .req    (req_elig),
        .rr_ptr (rr_ptr),
        .starve (starve),
        .gnt    (pick_gnt)
    );

    // Grants are suppressed while reset is held, even with requests pending
    assign gnt       = pick_gnt & {2{rst}};
    assign gnt_any   = |gnt;
    assign gnt_id    = gnt[PORT_HOST];
    assign gnt_wr    = gnt_id ? bus.p1_wr    : bus.p0_wr;
    assign gnt_addr  = gnt_id ? bus.p1_addr  : bus.p0_addr;
    assign gnt_wdata = gnt_id ? bus.p1_wdata : bus.p0_wdata;

    // Arbitration history: rr pointer favours the port not granted last; starvation count for port 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else if (!freeze) begin
            if (gnt_any) rr_ptr <= ~gnt_id;
            if (gnt[PORT_HOST] || !req[PORT_HOST]) starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)     starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Issue stage: register the granted access onto the dm pins with its source tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_addr_q   <= '0;
            dm_w_data_q <= '0;
            dm_rd_q     <= 1'b0;
            dm_wr_q     <= 1'b0;
            iss_tag     <= 1'b0;
        end else begin
            dm_rd_q <= gnt_any && !gnt_wr;
            dm_wr_q <= gnt_any && gnt_wr;
            if (gnt_any) begin
                dm_addr_q   <= gnt_addr;
                dm_w_data_q <= gnt_wdata;
                iss_tag     <= gnt_id;
            end
        end
    end

    // Return stage: follows the issue stage by one cycle while dm produces read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_vld <= 1'b0;
            ret_rd  <= 1'b0;
            ret_tag <= 1'b0;
        end else begin
            ret_vld <= dm_rd_q || dm_wr_q;
            ret_rd  <= dm_rd_q;
            ret_tag <= iss_tag;
        end
    end

    assign rvalid0 = ret_rd && (ret_tag == PORT_SPU);
    assign rvalid1 = ret_rd && (ret_tag == PORT_HOST);

    assign bus.p0_gnt    = gnt[PORT_SPU];
    assign bus.p1_gnt    = gnt[PORT_HOST];
    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rvalid0 ? bus.dm_r_data : '0;
    assign bus.p1_rdata  = rvalid1 ? bus.dm_r_data : '0;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_rd     = dm_rd_q;
    assign bus.dm_wr     = dm_wr_q;
    assign bus.dm_w_data = dm_w_data_q;
    assign bus.busy      = dm_rd_q || dm_wr_q || ret_vld;

endmodule

// File: tb/tb_spu_dm_arbiter.sv
// tb_spu_dm_arbiter: drives a round-robin and a fixed-priority arbiter side by side
// and compares every output, every cycle, against a transaction-level model.
// Build option: SPU_DM_ARB_LOCK_EN enables the lock stimulus.
module tb_spu_dm_arbiter;
    import spu_dm_pkg::*;

    localparam int SMAX = 4;
`ifdef SPU_DM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RAND = 1, M_CONT = 2, M_PRE = 3, M_WR = 4, M_RD = 5, M_LOCK = 6;

    typedef struct {
        logic g0, g1, rd, wr;
        logic [7:0] a;
        logic [15:0] wd;
        logic rv0, rv1;
        logic [15:0] rdt0, rdt1;
        logic busy;
    } obs_t;

    typedef struct {
        bit v, wr, port;
        logic [7:0] addr;
        logic [15:0] wd, rd;
    } acc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spu_dm_arbiter_if #(.AW(8), .DW(16)) if_rr ();
    spu_dm_arbiter_if #(.AW(8), .DW(16)) if_fx ();

    spu_dm_arbiter #(.AW(8), .DW(16), .PRIO_MODE(0), .STARVE_MAX(SMAX)) u_rr (
        .clk(clk), .rst(rst), .bus(if_rr));
    spu_dm_arbiter #(.AW(8), .DW(16), .PRIO_MODE(1), .STARVE_MAX(SMAX)) u_fx (
        .clk(clk), .rst(rst), .bus(if_fx));

    // Behavioural dm macros: registered read, write at the clock edge
    logic [15:0] dm_mem_rr [256];
    logic [15:0] dm_mem_fx [256];
    always @(posedge clk) begin
        if (if_rr.dm_wr) dm_mem_rr[if_rr.dm_addr] <= if_rr.dm_w_data;
        if (if_rr.dm_rd) if_rr.dm_r_data <= dm_mem_rr[if_rr.dm_addr];
    end
    always @(posedge clk) begin
        if (if_fx.dm_wr) dm_mem_fx[if_fx.dm_addr] <= if_fx.dm_w_data;
        if (if_fx.dm_rd) if_fx.dm_r_data <= dm_mem_fx[if_fx.dm_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Requester state per dut [d] and port [p]: a request stays up until granted
    bit          pend  [2][2];
    bit          pwr   [2][2];
    bit          plk   [2][2];
    logic [7:0]  paddr [2][2];
    logic [15:0] pwd   [2][2];
    int          pre_idx [2];
    int          lk_n    [2];

    // Reference model per dut
    int          last_gp [2];
    int          p1_wait [2];
    int          owner   [2];
    acc_t        st1 [2];
    acc_t        st2 [2];
    logic [7:0]  hold_addr [2];
    logic [15:0] hold_wd   [2];
    logic [15:0] ref_mem [2][64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t get_rr();
        obs_t o;
        o.g0 = if_rr.p0_gnt; o.g1 = if_rr.p1_gnt; o.rd = if_rr.dm_rd; o.wr = if_rr.dm_wr;
        o.a = if_rr.dm_addr; o.wd = if_rr.dm_w_data; o.rv0 = if_rr.p0_rvalid; o.rv1 = if_rr.p1_rvalid;
        o.rdt0 = if_rr.p0_rdata; o.rdt1 = if_rr.p1_rdata; o.busy = if_rr.busy;
        return o;
    endfunction

    function automatic obs_t get_fx();
        obs_t o;
        o.g0 = if_fx.p0_gnt; o.g1 = if_fx.p1_gnt; o.rd = if_fx.dm_rd; o.wr = if_fx.dm_wr;
        o.a = if_fx.dm_addr; o.wd = if_fx.dm_w_data; o.rv0 = if_fx.p0_rvalid; o.rv1 = if_fx.p1_rvalid;
        o.rdt0 = if_fx.p0_rdata; o.rdt1 = if_fx.p1_rdata; o.busy = if_fx.busy;
        return o;
    endfunction

    task automatic drive();
        if_rr.p0_req = pend[0][0]; if_rr.p0_wr = pwr[0][0]; if_rr.p0_addr = paddr[0][0]; if_rr.p0_wdata = pwd[0][0];
        if_rr.p1_req = pend[0][1]; if_rr.p1_wr = pwr[0][1]; if_rr.p1_addr = paddr[0][1]; if_rr.p1_wdata = pwd[0][1];
        if_fx.p0_req = pend[1][0]; if_fx.p0_wr = pwr[1][0]; if_fx.p0_addr = paddr[1][0]; if_fx.p0_wdata = pwd[1][0];
        if_fx.p1_req = pend[1][1]; if_fx.p1_wr = pwr[1][1]; if_fx.p1_addr = paddr[1][1]; if_fx.p1_wdata = pwd[1][1];
`ifdef SPU_DM_ARB_LOCK_EN
        if_rr.p0_lock = plk[0][0]; if_rr.p1_lock = plk[0][1];
        if_fx.p0_lock = plk[1][0]; if_fx.p1_lock = plk[1][1];
`endif
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_gp[d] = 1;     // port 0 is favoured after reset
            p1_wait[d] = 0;
            owner[d]   = -1;
            st1[d] = '{default: '0};
            st2[d] = '{default: '0};
            hold_addr[d] = '0;
            hold_wd[d]   = '0;
            for (int p = 0; p < 2; p++) begin
                pend[d][p] = 0; pwr[d][p] = 0; plk[d][p] = 0; paddr[d][p] = '0; pwd[d][p] = '0;
            end
        end
    endtask

    // Winner from the arbitration rules: lock owner, then tie-break by mode, else the lone requester
    function automatic int exp_winner(int d);
        if (owner[d] >= 0 && pend[d][owner[d]]) return owner[d];
        if (pend[d][0] && pend[d][1]) begin
            if (d == 0) return (last_gp[d] == 0) ? 1 : 0;
            return (p1_wait[d] == SMAX) ? 1 : 0;
        end
        if (pend[d][0]) return 0;
        if (pend[d][1]) return 1;
        return -1;
    endfunction

    task automatic check_zero(input int d, input obs_t o);
        string n = (d == 0) ? "rr" : "fx";
        chk({n, ".rst.p0_gnt"}, o.g0, 0);     chk({n, ".rst.p1_gnt"}, o.g1, 0);
        chk({n, ".rst.dm_rd"}, o.rd, 0);      chk({n, ".rst.dm_wr"}, o.wr, 0);
        chk({n, ".rst.dm_addr"}, o.a, 0);     chk({n, ".rst.dm_w_data"}, o.wd, 0);
        chk({n, ".rst.p0_rvalid"}, o.rv0, 0); chk({n, ".rst.p1_rvalid"}, o.rv1, 0);
        chk({n, ".rst.p0_rdata"}, o.rdt0, 0); chk({n, ".rst.p1_rdata"}, o.rdt1, 0);
        chk({n, ".rst.busy"}, o.busy, 0);
    endtask

    task automatic check_dut(input int d, input obs_t o);
        string n = (d == 0) ? "rr" : "fx";
        int w = exp_winner(d);
        bit erv0, erv1;
        acc_t a;
        erv0 = st2[d].v && !st2[d].wr && (st2[d].port == 1'b0);
        erv1 = st2[d].v && !st2[d].wr && (st2[d].port == 1'b1);
        chk({n, ".p0_gnt"}, o.g0, (w == 0));
        chk({n, ".p1_gnt"}, o.g1, (w == 1));
        chk({n, ".dm_rd"}, o.rd, st1[d].v && !st1[d].wr);
        chk({n, ".dm_wr"}, o.wr, st1[d].v && st1[d].wr);
        chk({n, ".dm_addr"}, o.a, hold_addr[d]);
        chk({n, ".dm_w_data"}, o.wd, hold_wd[d]);
        chk({n, ".p0_rvalid"}, o.rv0, erv0);
        chk({n, ".p1_rvalid"}, o.rv1, erv1);
        chk({n, ".p0_rdata"}, o.rdt0, erv0 ? st2[d].rd : 16'h0);
        chk({n, ".p1_rdata"}, o.rdt1, erv1 ? st2[d].rd : 16'h0);
        chk({n, ".busy"}, o.busy, st1[d].v || st2[d].v);

        a = '{default: '0};
        if (w >= 0) begin
            a.v = 1; a.wr = pwr[d][w]; a.port = w[0]; a.addr = paddr[d][w]; a.wd = pwd[d][w];
            if (a.wr) ref_mem[d][a.addr[5:0]] = a.wd;
            else      a.rd = ref_mem[d][a.addr[5:0]];
            hold_addr[d] = a.addr;
            hold_wd[d]   = a.wd;
        end
        if (owner[d] < 0) begin
            if (w >= 0) last_gp[d] = w;
            if (pend[d][1] && w != 1) p1_wait[d]++;
            else                      p1_wait[d] = 0;
        end
        if (w >= 0)                                   owner[d] = plk[d][w] ? w : -1;
        else if (owner[d] >= 0 && !pend[d][owner[d]]) owner[d] = -1;
        if (w >= 0) pend[d][w] = 0;
        st2[d] = st1[d];
        st1[d] = a;
    endtask

    task automatic gen(input int mode);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[d][p]) continue;
                case (mode)
                    M_RAND: if ($urandom_range(0, 9) < 6) begin
                        pend[d][p] = 1; pwr[d][p] = 1'($urandom_range(0, 1));
                        paddr[d][p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 63));
                        pwd[d][p] = 16'($urandom);
                        plk[d][p] = LOCK_EN && ($urandom_range(0, 3) == 0);
                    end
                    M_CONT: begin
                        pend[d][p] = 1; pwr[d][p] = 0; plk[d][p] = 0;
                        paddr[d][p] = (p == 0) ? 8'h10 : 8'h20; pwd[d][p] = 16'($urandom);
                    end
                    M_PRE: if (p == 1 && pre_idx[d] < 64) begin
                        pend[d][p] = 1; pwr[d][p] = 1; plk[d][p] = 0;
                        paddr[d][p] = 8'(pre_idx[d]); pwd[d][p] = 16'($urandom);
                        pre_idx[d]++;
                    end
                    M_WR: if (p == 1) begin
                        pend[d][p] = 1; pwr[d][p] = 1; plk[d][p] = 0; paddr[d][p] = 8'h05; pwd[d][p] = 16'hBEEF;
                    end
                    M_RD: if (p == 0) begin
                        pend[d][p] = 1; pwr[d][p] = 0; plk[d][p] = 0; paddr[d][p] = 8'h05; pwd[d][p] = 16'h0;
                    end
                    M_LOCK: if (p == 1) begin
                        pend[d][p] = 1; pwr[d][p] = 0; plk[d][p] = 0; paddr[d][p] = 8'h20; pwd[d][p] = 16'h0;
                    end else if (lk_n[d] < 4) begin
                        pend[d][p] = 1; pwr[d][p] = lk_n[d][0]; plk[d][p] = (lk_n[d] < 3);
                        paddr[d][p] = 8'h05; pwd[d][p] = 16'($urandom);
                        lk_n[d]++;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input int mode);
        @(posedge clk);
        #1;
        gen(mode);
        drive();
        @(negedge clk);
        check_dut(0, get_rr());
        check_dut(1, get_fx());
    endtask

    initial begin
        rst = 1'b0;
        pre_idx = '{0, 0};
        lk_n    = '{0, 0};
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        check_zero(0, get_rr());
        check_zero(1, get_fx());
        rst = 1'b1;

        repeat (70) step(M_PRE);        // host preload of addresses 0..63
        repeat (4) step(M_IDLE);        // busy drains after the last grant
        step(M_WR);                     // p1 writes 0xBEEF to 0x05
        step(M_RD);                     // p0 reads 0x05 on the next cycle
        repeat (4) step(M_IDLE);
        repeat (12) step(M_CONT);       // both ports reading 0x10 / 0x20

        // Asynchronous reset with a read on the dm pins
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero(0, get_rr());
        check_zero(1, get_fx());
        model_reset();
        drive();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) step(M_IDLE);        // no stray rvalid after release

        repeat (20) step(M_CONT);       // fixed mode: 4 x p0 then 1 x p1
        repeat (4) step(M_IDLE);
        repeat (400) step(M_RAND);
        repeat (4) step(M_IDLE);
        if (LOCK_EN) begin
            repeat (12) step(M_LOCK);
            repeat (4) step(M_IDLE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
